// File: rtl/avalon_mst.sv
// Avalon-MM single-word initiator: one read or write at a time from a valid/ready
// request port, returning read data or a timeout error on a valid/ready response port.
module avalon_mst #(
    parameter int addr_w = 32,
    parameter int to_w   = 8,
    parameter int to_lim = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [addr_w-1:0] req_addr,
    input  logic [31:0]       req_wd,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rd,
    output logic              resp_err,
    output logic [addr_w-1:0] address,
    output logic              read,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata,
    input  logic              waitrequest,
    input  logic              readdatavalid
);

    typedef enum logic [1:0] {IDLE, CMD, RDW, RESP} state_e;

    // Counter value seen in the last allowed cycle of a bus phase.
    localparam logic [to_w-1:0] CNT_LAST = to_w'(to_lim - 1);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rd_q, resp_rd_d;
    logic              resp_err_q, resp_err_d;
    logic [addr_w-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [31:0]       writedata_q, writedata_d;
    logic [3:0]        byteenable_q, byteenable_d;
    logic [to_w-1:0]   cnt_q, cnt_d;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a
        // signal unassigned; without these defaults synthesis would infer latches.
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    address_d    = req_addr;
                    writedata_d  = req_wd;
                    byteenable_d = req_be;
                    write_d      = req_we;
                    read_d       = !req_we;
                    cnt_d        = '0;
                    req_ready_d  = 1'b0;
                    state_d      = CMD;
                end
            end
            CMD: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (write_q || readdatavalid) begin
                        // Data arriving in the acceptance cycle itself completes the read.
                        resp_rd_d    = write_q ? 32'h0 : readdata;
                        resp_err_d   = 1'b0;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = RDW;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_rd_d    = 32'h0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RDW: begin
                if (readdatavalid) begin
                    resp_rd_d    = readdata;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_rd_d    = 32'h0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rd_q    <= 32'h0;
            resp_err_q   <= 1'b0;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'h0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_avalon_mst.sv
// Bench for avalon_mst: emulates an Avalon slave with scripted stall/data delays and
// compares every response against a transaction-level timing model.
module tb_avalon_mst;

    localparam int TO_LIM = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wd;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rd;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest, readdatavalid;
    logic [3:0]  byteenable;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          strobes;
        int          lat;
        logic [31:0] rd;
        logic        err;
        logic [31:0] a;
        logic [31:0] wdat;
        logic [3:0]  be;
        logic        saw_wr;
        logic        saw_rd;
        logic        stable;
        logic        both;
        logic        rr_bad;
        logic        hung;
    } obs_t;

    avalon_mst #(.addr_w(32), .to_w(8), .to_lim(TO_LIM)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wd(req_wd), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd(resp_rd), .resp_err(resp_err),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .waitrequest(waitrequest), .readdatavalid(readdatavalid)
    );

    always #5 clk = ~clk;

    // Transaction-level expectation: W stalled strobe cycles, read data D cycles after acceptance.
    task automatic model(input logic we, input int w, input int d, input logic [31:0] rdata,
                         output int strobes, output int lat, output logic [31:0] rd,
                         output logic err);
        int acc;
        if (w >= TO_LIM) begin
            strobes = TO_LIM; lat = TO_LIM + 1; rd = 32'h0; err = 1'b1;
        end else begin
            strobes = w + 1;
            acc = w + 1;
            if (we) begin
                lat = acc + 1; rd = 32'h0; err = 1'b0;
            end else if (d <= TO_LIM) begin
                lat = acc + d + 1; rd = rdata; err = 1'b0;
            end else begin
                lat = acc + TO_LIM + 1; rd = 32'h0; err = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issues one command and plays the slave; all times are cycles after the request handshake.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input int w, input int d,
                           input logic [31:0] rdata, input int rr, output obs_t o);
        int c, acc, first;
        logic hs;
        o.strobes = 0; o.lat = -1; o.rd = 'x; o.err = 'x; o.a = 'x; o.wdat = 'x; o.be = 'x;
        o.saw_wr = 0; o.saw_rd = 0; o.stable = 1; o.both = 0; o.rr_bad = 0; o.hung = 1;
        c = 0;
        while (!req_ready && c < 50) begin
            @(posedge clk); #1; c++;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        c = 1; acc = -1; first = -1;
        while (c < 1000) begin
            if (read && write) o.both = 1;
            if (read || write) begin
                o.strobes++;
                if (o.strobes == 1) begin
                    o.a = address; o.wdat = writedata; o.be = byteenable;
                    o.saw_wr = write; o.saw_rd = read;
                end else if (address !== o.a || writedata !== o.wdat || byteenable !== o.be ||
                             write !== o.saw_wr || read !== o.saw_rd) begin
                    o.stable = 0;
                end
                waitrequest = (o.strobes <= w);
                if (!waitrequest && acc < 0) acc = c;
            end else begin
                waitrequest = 1'b0;
            end
            readdatavalid = (acc >= 0 && !we && c == acc + d);
            readdata = readdatavalid ? rdata : $urandom;
            if (resp_valid) begin
                if (first < 0) begin
                    first = c; o.lat = c; o.rd = resp_rd; o.err = resp_err;
                end else if (resp_rd !== o.rd || resp_err !== o.err) begin
                    o.stable = 0;
                end
                if (req_ready) o.rr_bad = 1;
                resp_ready = (c >= first + rr);
            end else begin
                resp_ready = 1'b0;
            end
            hs = resp_valid && resp_ready;
            @(posedge clk); #1;
            c++;
            if (hs) begin
                o.hung = 0;
                break;
            end
        end
        waitrequest = 1'b0; readdatavalid = 1'b0; resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({req_ready, resp_valid, read, write, resp_err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, read, write, resp_err});
        end
        n_cmp++;
        if ({address, writedata, byteenable, resp_rd} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", address, writedata, byteenable, resp_rd);
        end
    endtask

    task automatic test_write();
        obs_t o;
        apply_reset();
        run_txn(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 0, 0, 32'h0, 0, o);
        n_cmp++;
        if ({o.saw_wr, o.saw_rd, o.a, o.wdat, o.be} !== {2'b10, 32'h10, 32'hA5A5_5A5A, 4'hF}) begin
            n_bad++;
            $display("FAIL write_bus: got wr=%b rd=%b a=%h d=%h be=%h want wr=1 rd=0 a=10 d=a5a55a5a be=f",
                     o.saw_wr, o.saw_rd, o.a, o.wdat, o.be);
        end
        n_cmp++;
        if (o.strobes !== 1 || o.lat !== 2 || o.err !== 1'b0 || o.rd !== 32'h0 || o.hung) begin
            n_bad++;
            $display("FAIL write_resp: got strobes=%0d lat=%0d err=%b rd=%h want 1 2 0 0",
                     o.strobes, o.lat, o.err, o.rd);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        apply_reset();
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 3, 2, 32'h1234_5678, 1, o);
        n_cmp++;
        if (o.strobes !== 4 || !o.stable || o.saw_rd !== 1'b1 || o.a !== 32'h4) begin
            n_bad++;
            $display("FAIL read_hold: got strobes=%0d stable=%b rd=%b a=%h want 4 1 1 4",
                     o.strobes, o.stable, o.saw_rd, o.a);
        end
        n_cmp++;
        if (o.rd !== 32'h1234_5678 || o.err !== 1'b0 || o.lat !== 7) begin
            n_bad++;
            $display("FAIL read_data: got rd=%h err=%b lat=%0d want 12345678 0 7", o.rd, o.err, o.lat);
        end
    endtask

    task automatic test_cmd_timeout();
        obs_t o;
        apply_reset();
        run_txn(1'b1, 32'h20, 32'hDEAD_BEEF, 4'h3, 100000, 0, 32'h0, 2, o);
        n_cmp++;
        if (o.strobes !== TO_LIM || o.err !== 1'b1 || o.rd !== 32'h0 || o.lat !== TO_LIM + 1) begin
            n_bad++;
            $display("FAIL cmd_timeout: got strobes=%0d err=%b rd=%h lat=%0d want %0d 1 0 %0d",
                     o.strobes, o.err, o.rd, o.lat, TO_LIM, TO_LIM + 1);
        end
        run_txn(1'b1, 32'h24, 32'h0BAD_F00D, 4'hF, 1, 0, 32'h0, 0, o);
        n_cmp++;
        if (o.err !== 1'b0 || o.lat !== 3 || o.a !== 32'h24 || o.wdat !== 32'h0BAD_F00D) begin
            n_bad++;
            $display("FAIL after_timeout: got err=%b lat=%0d a=%h d=%h want 0 3 24 0badf00d",
                     o.err, o.lat, o.a, o.wdat);
        end
    endtask

    task automatic test_read_timeout();
        obs_t o;
        apply_reset();
        run_txn(1'b0, 32'h30, 32'h0, 4'hF, 0, TO_LIM + 3, 32'hCAFE_0001, 5, o);
        n_cmp++;
        if (o.err !== 1'b1 || o.rd !== 32'h0 || o.lat !== TO_LIM + 2 || !o.stable) begin
            n_bad++;
            $display("FAIL read_timeout: got err=%b rd=%h lat=%0d stable=%b want 1 0 %0d 1",
                     o.err, o.rd, o.lat, o.stable, TO_LIM + 2);
        end
        run_txn(1'b0, 32'h34, 32'h0, 4'hF, 0, 1, 32'hCAFE_0002, 0, o);
        n_cmp++;
        if (o.err !== 1'b0 || o.rd !== 32'hCAFE_0002 || o.lat !== 3) begin
            n_bad++;
            $display("FAIL read_after_to: got err=%b rd=%h lat=%0d want 0 cafe0002 3", o.err, o.rd, o.lat);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wd = 32'h1111_1111; req_be = 4'hF;
        waitrequest = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h44; req_wd = 32'h2222_2222;
        n_cmp++;
        if (write !== 1'b1 || address !== 32'h40) begin
            n_bad++;
            $display("FAIL bp_first: got write=%b addr=%h want 1 40", write, address);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({resp_valid, req_ready, write, read, resp_err, resp_rd} !== {5'b10000, 32'h0}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b wr=%b rd=%b err=%b data=%h want 1 0 0 0 0 0",
                         i, resp_valid, req_ready, write, read, resp_err, resp_rd);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || write !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: got v=%b rdy=%b wr=%b want 0 1 0", resp_valid, req_ready, write);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if (write !== 1'b1 || address !== 32'h44 || writedata !== 32'h2222_2222) begin
            n_bad++;
            $display("FAIL bp_second: got wr=%b a=%h d=%h want 1 44 22222222", write, address, writedata);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wd = 32'h5; req_be = 4'h1;
        @(posedge clk); #1;
        req_valid = 1'b0; waitrequest = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (write !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: got write=%b want 1", write);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({write, read, resp_valid, req_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstmid_post: got wr/rd/v/rdy=%b want 0001", {write, read, resp_valid, req_ready});
        end
        waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0 || write !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_noresp: got v=%b wr=%b want 0 0", resp_valid, write);
        end
    endtask

    // Shared by the limit-edge and random sweeps: run one scripted case and compare with the model.
    task automatic test_cases(input string tag, input int n, input bit rnd);
        obs_t o;
        int w, d, rr, es, el;
        logic we, ee;
        logic [31:0] addr, wd, rdata, erd;
        logic [3:0] be;
        apply_reset();
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                we = 1'($urandom); w = $urandom_range(0, 4); d = $urandom_range(0, 4);
                rr = $urandom_range(0, 3);
            end else begin
                we = (i < 2);
                w = (i == 0) ? TO_LIM - 1 : (i == 1) ? TO_LIM : 0;
                d = (i == 2) ? TO_LIM : TO_LIM + 1;
                rr = 1;
            end
            addr = $urandom & 32'hFFFF_FFFC; wd = $urandom; rdata = $urandom; be = 4'($urandom);
            run_txn(we, addr, wd, be, w, d, rdata, rr, o);
            model(we, w, d, rdata, es, el, erd, ee);
            n_cmp++;
            if (o.hung || o.strobes !== es || o.lat !== el || o.rd !== erd || o.err !== ee) begin
                n_bad++;
                $display("FAIL %s[%0d] resp: got s=%0d lat=%0d rd=%h err=%b want %0d %0d %h %b (we=%b w=%0d d=%0d)",
                         tag, i, o.strobes, o.lat, o.rd, o.err, es, el, erd, ee, we, w, d);
            end
            n_cmp++;
            if ({o.saw_wr, o.saw_rd, o.a, o.wdat, o.be, o.stable, o.both, o.rr_bad} !==
                {we, !we, addr, wd, be, 3'b100}) begin
                n_bad++;
                $display("FAIL %s[%0d] bus: got wr=%b rd=%b a=%h d=%h be=%h st=%b both=%b rr=%b want %b %b %h %h %h 1 0 0",
                         tag, i, o.saw_wr, o.saw_rd, o.a, o.wdat, o.be, o.stable, o.both, o.rr_bad,
                         we, !we, addr, wd, be);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0; req_be = '0;
        resp_ready = 1'b0; readdata = '0; waitrequest = 1'b0; readdatavalid = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_write();
        test_read_wait();
        test_cmd_timeout();
        test_read_timeout();
        test_backpressure();
        test_reset_mid();
        test_cases("limit", 4, 1'b0);
        test_cases("random", 40, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
